// File: rtl/cp0_exc_regfile.sv
// cp0_exc_regfile: CP0 register block (BadVAddr, Count, Compare, Status, Cause, EPC).
// Runs exception entry/ERET, the Count/Compare timer, and raises a registered
// interrupt request to the exception stage. It sits beside writeback and
// serves MTC0/MFC0.
//
// Ports:
//   clk, reset (async, active low)
//   mtc0_we/mtc0_addr/mtc0_wdata   MTC0 write port (sel 0 only)
//   mfc0_addr/mfc0_rdata           combinational read port (pre-edge state)
//   exc_valid/exc_code/exc_pc/exc_bd/exc_badvaddr_we/exc_badvaddr  exception commit
//   eret                           ERET commit
//   hw_int                         level hardware interrupts -> IP[7:2]
//   status_out/cause_out/epc_out   current register values
//   timer_int                      Cause.TI
//   int_req                        registered interrupt request
module cp0_exc_regfile #(
   parameter int DATA_W    = 32,
   parameter int HW_INT_N  = 6,
   parameter int COUNT_DIV = 2,
   parameter int RESET_BEV = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mtc0_we,
   input  logic [4:0]        mtc0_addr,
   input  logic [DATA_W-1:0] mtc0_wdata,
   input  logic [4:0]        mfc0_addr,
   output logic [DATA_W-1:0] mfc0_rdata,
   input  logic              exc_valid,
   input  logic [4:0]        exc_code,
   input  logic [DATA_W-1:0] exc_pc,
   input  logic              exc_bd,
   input  logic              exc_badvaddr_we,
   input  logic [DATA_W-1:0] exc_badvaddr,
   input  logic              eret,
   input  logic [HW_INT_N-1:0] hw_int,
   output logic [DATA_W-1:0] status_out,
   output logic [DATA_W-1:0] cause_out,
   output logic [DATA_W-1:0] epc_out,
   output logic              timer_int,
   output logic              int_req
);

   localparam logic [4:0] A_BADVADDR = 5'd8;
   localparam logic [4:0] A_COUNT    = 5'd9;
   localparam logic [4:0] A_COMPARE  = 5'd11;
   localparam logic [4:0] A_STATUS   = 5'd12;
   localparam logic [4:0] A_CAUSE    = 5'd13;
   localparam logic [4:0] A_EPC      = 5'd14;
   localparam int PRE_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   logic [DATA_W-1:0] badvaddr, count, compare, epc;
   logic [7:0]        im;
   logic              exl, ie;
   logic              bd, ti;
   logic [4:0]        exc_code_q;
   logic [1:0]        ip_sw;
   logic [5:0]        ip_hw;
   logic [PRE_W-1:0]  prescale;

   logic [5:0]        hw_ext;
   logic [7:0]        ip;
   logic [DATA_W-1:0] status_val, cause_val, count_inc;
   logic              wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic              pre_wrap, count_tick;

   always_comb begin
      hw_ext = '0;
      hw_ext[HW_INT_N-1:0] = hw_int;
   end

   // IP7 is shared between hardware line 5 and the timer.
   assign ip = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};

   always_comb begin
      status_val     = '0;
      status_val[22] = 1'(RESET_BEV);
      status_val[15:8] = im;
      status_val[1]  = exl;
      status_val[0]  = ie;
   end

   always_comb begin
      cause_val       = '0;
      cause_val[31]   = bd;
      cause_val[30]   = ti;
      cause_val[15:8] = ip;
      cause_val[6:2]  = exc_code_q;
   end

   assign wr_count   = mtc0_we && (mtc0_addr == A_COUNT);
   assign wr_compare = mtc0_we && (mtc0_addr == A_COMPARE);
   assign wr_status  = mtc0_we && (mtc0_addr == A_STATUS);
   assign wr_cause   = mtc0_we && (mtc0_addr == A_CAUSE);
   assign wr_epc     = mtc0_we && (mtc0_addr == A_EPC);

   assign pre_wrap   = (prescale == PRE_W'(COUNT_DIV - 1));
   assign count_tick = pre_wrap && !wr_count;
   assign count_inc  = count + DATA_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         badvaddr   <= '0;
         count      <= '0;
         compare    <= '0;
         epc        <= '0;
         im         <= '0;
         exl        <= 1'b0;
         ie         <= 1'b0;
         bd         <= 1'b0;
         ti         <= 1'b0;
         exc_code_q <= '0;
         ip_sw      <= '0;
         ip_hw      <= '0;
         prescale   <= '0;
         int_req    <= 1'b0;
      end else begin
         ip_hw <= hw_ext;

         if (wr_count) begin
            count    <= mtc0_wdata;
            prescale <= '0;
         end else if (pre_wrap) begin
            count    <= count_inc;
            prescale <= '0;
         end else begin
            prescale <= prescale + PRE_W'(1);
         end

         // A Compare write clears TI even if Count hits Compare on the same edge.
         if (wr_compare) begin
            compare <= mtc0_wdata;
            ti      <= 1'b0;
         end else if (count_tick && (count_inc == compare)) begin
            ti <= 1'b1;
         end

         if (exc_valid) begin
            exl        <= 1'b1;
            exc_code_q <= exc_code;
            // Nested exceptions keep the original return point.
            if (!exl) begin
               epc <= exc_bd ? (exc_pc - DATA_W'(4)) : exc_pc;
               bd  <= exc_bd;
            end
            if (exc_badvaddr_we) badvaddr <= exc_badvaddr;
         end else if (eret) begin
            exl <= 1'b0;
         end else begin
            if (wr_status) begin
               im  <= mtc0_wdata[15:8];
               exl <= mtc0_wdata[1];
               ie  <= mtc0_wdata[0];
            end
            if (wr_cause) ip_sw <= mtc0_wdata[1:0];
            if (wr_epc)   epc   <= mtc0_wdata;
         end

         int_req <= !exc_valid && ie && !exl && (|(im & ip));
      end
   end

   always_comb begin
      case (mfc0_addr)
         A_BADVADDR: mfc0_rdata = badvaddr;
         A_COUNT:    mfc0_rdata = count;
         A_COMPARE:  mfc0_rdata = compare;
         A_STATUS:   mfc0_rdata = status_val;
         A_CAUSE:    mfc0_rdata = cause_val;
         A_EPC:      mfc0_rdata = epc;
         default:    mfc0_rdata = '0;
      endcase
   end

   assign status_out = status_val;
   assign cause_out  = cause_val;
   assign epc_out    = epc;
   assign timer_int  = ti;

endmodule

// File: tb/tb_cp0_exc_regfile.sv
module tb_cp0_exc_regfile;

   logic        clk;
   logic        reset;
   logic        mtc0_we;
   logic [4:0]  mtc0_addr;
   logic [31:0] mtc0_wdata;
   logic [4:0]  mfc0_addr;
   logic [31:0] mfc0_rdata;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_bd;
   logic        exc_badvaddr_we;
   logic [31:0] exc_badvaddr;
   logic        eret;
   logic [5:0]  hw_int;
   logic [31:0] status_out, cause_out, epc_out;
   logic        timer_int, int_req;

   int checks = 0;
   int errors = 0;

   cp0_exc_regfile #(.DATA_W(32), .HW_INT_N(6), .COUNT_DIV(2), .RESET_BEV(1)) dut (
      .clk(clk), .reset(reset),
      .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
      .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
      .exc_badvaddr_we(exc_badvaddr_we), .exc_badvaddr(exc_badvaddr),
      .eret(eret), .hw_int(hw_int),
      .status_out(status_out), .cause_out(cause_out), .epc_out(epc_out),
      .timer_int(timer_int), .int_req(int_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic        exc;
      logic [4:0]  code;
      logic [31:0] pc;
      logic        bd;
      logic        bva_we;
      logic [31:0] bva;
      logic        eret;
      logic [5:0]  hw;
      logic [4:0]  raddr;
      logic [31:0] exp;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      mtc0_we = 1'b0;
      exc_valid = 1'b0;
      exc_badvaddr_we = 1'b0;
      eret = 1'b0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      mtc0_we = 1'b1;
      mtc0_addr = a;
      mtc0_wdata = d;
      tick();
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      mfc0_addr = a;
      #1;
      d = mfc0_rdata;
   endtask

   function automatic vec_t mv(input logic we, input logic [4:0] a, input logic [31:0] wd,
                               input logic exc, input logic [4:0] code, input logic [31:0] pc,
                               input logic bd, input logic bvwe, input logic [31:0] bva,
                               input logic er, input logic [5:0] hw, input logic [4:0] ra,
                               input logic [31:0] exp, input logic irq);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = wd; v.exc = exc; v.code = code; v.pc = pc;
      v.bd = bd; v.bva_we = bvwe; v.bva = bva; v.eret = er; v.hw = hw;
      v.raddr = ra; v.exp = exp; v.exp_irq = irq;
      return v;
   endfunction

   logic [31:0] r;
   int          n;

   initial begin
      reset = 1'b0;
      mtc0_we = 1'b0; mtc0_addr = '0; mtc0_wdata = '0; mfc0_addr = 5'd9;
      exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
      exc_badvaddr_we = 1'b0; exc_badvaddr = '0; eret = 1'b0; hw_int = '0;

      //                we    addr   wdata          exc   code   pc             bd    bvwe  bva            eret  hw     raddr  expected       irq
      vecs[0]  = mv(1'b1, 5'd12, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd12, 32'h0040_FF03, 1'b0);
      vecs[1]  = mv(1'b1, 5'd12, 32'h0,         1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd12, 32'h0040_0000, 1'b0);
      vecs[2]  = mv(1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd13, 32'h0000_0300, 1'b0);
      vecs[3]  = mv(1'b1, 5'd12, 32'h0000_0101, 1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd12, 32'h0040_0101, 1'b0);
      vecs[4]  = mv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd13, 32'h0000_0300, 1'b1);
      vecs[5]  = mv(1'b1, 5'd8,  32'h0000_1234, 1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd8,  32'h0,         1'b1);
      vecs[6]  = mv(1'b1, 5'd10, 32'h0000_DEAD, 1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd10, 32'h0,         1'b1);
      vecs[7]  = mv(1'b1, 5'd13, 32'h0,         1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd13, 32'h0,         1'b1);
      vecs[8]  = mv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd12, 32'h0040_0101, 1'b0);
      vecs[9]  = mv(1'b1, 5'd14, 32'h1000_0000, 1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd14, 32'h1000_0000, 1'b0);
      vecs[10] = mv(1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  32'hBFC0_0100,  1'b1, 1'b1, 32'h0000_1233, 1'b0, 6'd0, 5'd14, 32'hBFC0_00FC, 1'b0);
      vecs[11] = mv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd8,  32'h0000_1233, 1'b0);
      vecs[12] = mv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd13, 32'h8000_0010, 1'b0);
      vecs[13] = mv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd12, 32'h0040_0103, 1'b0);
      vecs[14] = mv(1'b0, 5'd0,  32'h0,         1'b1, 5'd12, 32'h8000_0000,  1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd14, 32'hBFC0_00FC, 1'b0);
      vecs[15] = mv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd13, 32'h8000_0030, 1'b0);
      vecs[16] = mv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b1, 6'd0, 5'd12, 32'h0040_0101, 1'b0);
      vecs[17] = mv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd14, 32'hBFC0_00FC, 1'b0);
      vecs[18] = mv(1'b1, 5'd12, 32'h0,         1'b1, 5'd0,  32'h0000_0100,  1'b0, 1'b0, 32'h0,         1'b0, 6'd0, 5'd12, 32'h0040_0103, 1'b0);
      vecs[19] = mv(1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h0000_0300,  1'b0, 1'b0, 32'h0,         1'b1, 6'd0, 5'd12, 32'h0040_0103, 1'b0);
      vecs[20] = mv(1'b1, 5'd12, 32'h0,         1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b1, 6'd0, 5'd12, 32'h0040_0101, 1'b0);
      vecs[21] = mv(1'b1, 5'd12, 32'h0000_0401, 1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd1, 5'd12, 32'h0040_0401, 1'b0);
      vecs[22] = mv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 6'd1, 5'd13, 32'h0000_0400, 1'b1);
      vecs[23] = mv(1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h0000_0200,  1'b0, 1'b0, 32'h0,         1'b0, 6'd1, 5'd12, 32'h0040_0403, 1'b0);

      // Reset state
      #3;
      chk("reset_status", status_out, 32'h0040_0000);
      chk("reset_cause", cause_out, 32'h0);
      chk("reset_epc", epc_out, 32'h0);
      chk("reset_count", mfc0_rdata, 32'h0);
      chk("reset_int_req", {31'b0, int_req}, 32'h0);
      #9 reset = 1'b1;

      // Table-driven single-cycle vectors
      for (int i = 0; i < 24; i++) begin
         mtc0_we = vecs[i].we; mtc0_addr = vecs[i].addr; mtc0_wdata = vecs[i].wdata;
         exc_valid = vecs[i].exc; exc_code = vecs[i].code; exc_pc = vecs[i].pc;
         exc_bd = vecs[i].bd; exc_badvaddr_we = vecs[i].bva_we; exc_badvaddr = vecs[i].bva;
         eret = vecs[i].eret; hw_int = vecs[i].hw;
         tick();
         rd(vecs[i].raddr, r);
         chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp);
         chk($sformatf("vec%0d_int_req", i), {31'b0, int_req}, {31'b0, vecs[i].exp_irq});
      end
      chk("exc_epc_out", epc_out, 32'h0000_0200);

      // Count/Compare timer
      hw_int = '0;
      eret = 1'b1;
      tick();
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      mtc0(5'd12, 32'h0000_8001);
      n = 1;
      while (!timer_int && n < 40) begin
         tick();
         n++;
      end
      chk("timer_edges", n, 10);
      rd(5'd9, r);
      chk("timer_count", r, 32'd5);
      chk("timer_cause", cause_out, 32'h4000_8000);
      chk("timer_int_req_lat0", {31'b0, int_req}, 32'h0);
      tick();
      chk("timer_int_req_lat1", {31'b0, int_req}, 32'h1);
      mtc0(5'd11, 32'd9);
      chk("timer_clear", {31'b0, timer_int}, 32'h0);
      rd(5'd11, r);
      chk("compare_rd", r, 32'd9);

      // Count wrap
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd(5'd9, r);
      chk("wrap_load", r, 32'hFFFF_FFFF);
      tick();
      rd(5'd9, r);
      chk("wrap_hold", r, 32'hFFFF_FFFF);
      tick();
      rd(5'd9, r);
      chk("wrap_zero", r, 32'h0);
      chk("wrap_no_ti", {31'b0, timer_int}, 32'h0);

      // Async reset mid-count with an active interrupt
      mtc0(5'd12, 32'h0000_0401);
      hw_int = 6'd1;
      mtc0(5'd9, 32'h55);
      tick();
      tick();
      chk("pre_reset_int_req", {31'b0, int_req}, 32'h1);
      mfc0_addr = 5'd9;
      #2 reset = 1'b0;
      #1;
      chk("async_count", mfc0_rdata, 32'h0);
      chk("async_status", status_out, 32'h0040_0000);
      chk("async_int_req", {31'b0, int_req}, 32'h0);
      chk("async_timer_int", {31'b0, timer_int}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
